// File: rtl/score_text_writer.sv
// Converts a binary score to decimal with a sequential double-dabble, then writes
// one letter code per cycle into the character buffer, most-significant digit first.
module score_text_writer #(
  parameter int         SCORE_W    = 14,
  parameter int         NUM_DIGITS = 4,
  parameter logic [6:0] START_CELL = 7'd6,
  parameter logic [5:0] DIGIT_BASE = 6'd10,
  parameter logic [5:0] BLANK_CODE = 6'd0,
  parameter bit         LEAD_BLANK = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [SCORE_W-1:0] score,
  output logic               busy,
  output logic               done,
  output logic               wr_en,
  output logic [6:0]         wr_addr,
  output logic [5:0]         wr_letter
);

  localparam int BCD_W   = 4 * NUM_DIGITS;
  localparam int MAX_VAL = 10 ** NUM_DIGITS - 1;
  localparam int CNT_W   = $clog2((SCORE_W > NUM_DIGITS) ? SCORE_W : NUM_DIGITS) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_WRITE,
    S_FINISH
  } state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [CNT_W-1:0]   r_cnt;
  logic [BCD_W-1:0]   r_bcd;
  logic [SCORE_W-1:0] r_shift;
  logic               r_leadZero;

  logic [SCORE_W-1:0] w_sat;
  logic [BCD_W-1:0]   w_bcdAdj;
  logic [3:0]         w_digit;
  logic               w_lastShift;
  logic               w_lastDigit;
  logic               w_blank;

  logic               w_busyNext;
  logic               w_doneNext;
  logic               w_wrEnNext;
  logic [6:0]         w_addrNext;
  logic [5:0]         w_letterNext;

  assign w_sat       = (32'(score) > MAX_VAL) ? SCORE_W'(MAX_VAL) : score;
  assign w_digit     = r_bcd[BCD_W-1 -: 4];
  assign w_lastShift = (r_cnt == CNT_W'(SCORE_W - 1));
  assign w_lastDigit = (r_cnt == CNT_W'(NUM_DIGITS - 1));
  // The units digit is always shown, even when the whole value is zero.
  assign w_blank     = LEAD_BLANK && r_leadZero && (w_digit == 4'd0) && !w_lastDigit;

  always_comb begin
    w_bcdAdj = r_bcd;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) begin
        w_bcdAdj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:    if (start)       w_nextState = S_CONVERT;
      S_CONVERT: if (w_lastShift) w_nextState = S_WRITE;
      S_WRITE:   if (w_lastDigit) w_nextState = S_FINISH;
      S_FINISH:                   w_nextState = S_IDLE;
      default:                    w_nextState = S_IDLE;
    endcase
  end

  always_comb begin
    w_busyNext   = 1'b0;
    w_doneNext   = 1'b0;
    w_wrEnNext   = 1'b0;
    w_addrNext   = wr_addr;
    w_letterNext = wr_letter;
    case (r_state)
      S_IDLE:    w_busyNext = start;
      S_CONVERT: w_busyNext = 1'b1;
      S_WRITE: begin
        w_busyNext   = 1'b1;
        w_wrEnNext   = 1'b1;
        w_addrNext   = START_CELL + 7'(r_cnt);
        w_letterNext = w_blank ? BLANK_CODE : (DIGIT_BASE + {2'b00, w_digit});
      end
      S_FINISH:  w_doneNext = 1'b1;
      default:   w_busyNext = 1'b0;
    endcase
  end

  // Conversion shifts {bcd, sat} left; the write phase then shifts bcd a nibble at a time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_bcd      <= '0;
      r_shift    <= '0;
      r_leadZero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_bcd   <= '0;
            r_shift <= w_sat;
            r_cnt   <= '0;
          end
        end
        S_CONVERT: begin
          {r_bcd, r_shift} <= {w_bcdAdj, r_shift} << 1;
          r_cnt            <= w_lastShift ? '0 : r_cnt + 1'b1;
          r_leadZero       <= 1'b1;
        end
        S_WRITE: begin
          r_bcd      <= r_bcd << 4;
          r_cnt      <= r_cnt + 1'b1;
          r_leadZero <= r_leadZero && (w_digit == 4'd0);
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= 7'd0;
      wr_letter <= 6'd0;
    end else begin
      busy      <= w_busyNext;
      done      <= w_doneNext;
      wr_en     <= w_wrEnNext;
      wr_addr   <= w_addrNext;
      wr_letter <= w_letterNext;
    end
  end

endmodule

// File: tb/tb_score_text_writer.sv
// Scoreboard bench for score_text_writer: three instances (defaults, no leading
// blanking, wrapping start cell) share stimulus; a monitor checks every write and done.
module tb_score_text_writer;

  localparam int SCORE_W    = 14;
  localparam int NUM_DIGITS = 4;
  localparam int MAXV       = 10 ** NUM_DIGITS - 1;
  localparam int PERIOD     = SCORE_W + NUM_DIGITS + 2;

  typedef struct {
    int cyc;
    int addr;
    int letter;
  } wr_t;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [SCORE_W-1:0] score;
  logic [2:0]         busyO;
  logic [2:0]         doneO;
  logic [2:0]         wrEn;
  logic [6:0]         wrAddr   [3];
  logic [5:0]         wrLetter [3];

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  int  leadBlank [3] = '{1, 0, 1};
  int  startCell [3] = '{6, 6, 126};
  wr_t expQ  [3][$];
  int  doneQ [3][$];

  score_text_writer u0 (
    .clk(clk), .reset(reset), .start(start), .score(score),
    .busy(busyO[0]), .done(doneO[0]), .wr_en(wrEn[0]),
    .wr_addr(wrAddr[0]), .wr_letter(wrLetter[0])
  );

  score_text_writer #(.LEAD_BLANK(1'b0)) u1 (
    .clk(clk), .reset(reset), .start(start), .score(score),
    .busy(busyO[1]), .done(doneO[1]), .wr_en(wrEn[1]),
    .wr_addr(wrAddr[1]), .wr_letter(wrLetter[1])
  );

  score_text_writer #(.START_CELL(7'd126)) u2 (
    .clk(clk), .reset(reset), .start(start), .score(score),
    .busy(busyO[2]), .done(doneO[2]), .wr_en(wrEn[2]),
    .wr_addr(wrAddr[2]), .wr_letter(wrLetter[2])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d (cyc %0d)", name, actual, expected, cyc);
    end
  endtask

  // Expected writes come from plain decimal arithmetic on the saturated score.
  task automatic pushExpected(input int s, input int c0);
    int  sat;
    int  p;
    int  d;
    bit  blank;
    wr_t e;
    sat = (s > MAXV) ? MAXV : s;
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        p        = 10 ** (NUM_DIGITS - 1 - k);
        d        = (sat / p) % 10;
        blank    = (leadBlank[n] != 0) && (k < NUM_DIGITS - 1) && (sat < p);
        e.cyc    = c0 + SCORE_W + 1 + k;
        e.addr   = (startCell[n] + k) % 128;
        e.letter = blank ? 0 : 10 + d;
        expQ[n].push_back(e);
      end
      doneQ[n].push_back(c0 + SCORE_W + NUM_DIGITS + 1);
    end
  endtask

  task automatic applyStimulus(input int s, input bit repulse);
    int c0;
    int busyCnt;
    bit seen;
    @(negedge clk);
    start = 1'b1;
    score = SCORE_W'(s);
    @(posedge clk);
    #1;
    c0    = cyc;
    start = 1'b0;
    pushExpected(s, c0);
    busyCnt = 0;
    seen    = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (repulse && (cyc == c0 + 4 || cyc == c0 + 19)) start = 1'b0;
      if (repulse && (cyc == c0 + 3 || cyc == c0 + 18)) begin
        start = 1'b1;
        score = SCORE_W'((s + 1111) % 16384);
      end
      if (busyO[0]) busyCnt++;
      if (doneO[0]) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b0;
    checkOutput($sformatf("busy_cycles_%0d", s), busyCnt, SCORE_W + NUM_DIGITS + 1);
    checkOutput($sformatf("done_seen_%0d", s), int'(seen), 1);
  endtask

  // Monitor: every write strobe and done pulse must match the head of its queue.
  always @(negedge clk) begin
    wr_t e;
    if (reset === 1'b0) begin
      for (int n = 0; n < 3; n++) begin
        if (wrEn[n] === 1'b1) begin
          if (expQ[n].size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_write inst=%0d actual addr=%0d letter=%0d required=none",
                     n, wrAddr[n], wrLetter[n]);
          end else begin
            e = expQ[n].pop_front();
            checkOutput($sformatf("write_cycle_inst%0d", n), cyc, e.cyc);
            checkOutput($sformatf("write_addr_inst%0d", n), int'(wrAddr[n]), e.addr);
            checkOutput($sformatf("write_letter_inst%0d", n), int'(wrLetter[n]), e.letter);
          end
        end
        if (doneO[n] === 1'b1) begin
          if (doneQ[n].size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_done inst=%0d actual=1 required=0", n);
          end else begin
            checkOutput($sformatf("done_cycle_inst%0d", n), cyc, doneQ[n].pop_front());
          end
        end
      end
    end
  end

  initial begin
    int c0;
    reset = 1'b0;
    start = 1'b0;
    score = '0;
    #1 reset = 1'b1;
    #1;
    for (int n = 0; n < 3; n++) begin
      checkOutput($sformatf("rst_wr_en_%0d", n), int'(wrEn[n]), 0);
      checkOutput($sformatf("rst_addr_%0d", n), int'(wrAddr[n]), 0);
      checkOutput($sformatf("rst_letter_%0d", n), int'(wrLetter[n]), 0);
      checkOutput($sformatf("rst_busy_%0d", n), int'(busyO[n]), 0);
      checkOutput($sformatf("rst_done_%0d", n), int'(doneO[n]), 0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;

    applyStimulus(1234, 1'b0);
    applyStimulus(7, 1'b0);
    applyStimulus(0, 1'b0);
    applyStimulus(16383, 1'b0);
    applyStimulus(4321, 1'b0);
    applyStimulus(9999, 1'b0);
    applyStimulus(10000, 1'b0);
    applyStimulus(2468, 1'b1);

    // Start held high: second conversion accepted exactly one period later with the new score.
    @(negedge clk);
    start = 1'b1;
    score = SCORE_W'(4090);
    @(posedge clk);
    #1;
    c0 = cyc;
    pushExpected(4090, c0);
    score = SCORE_W'(321);
    pushExpected(321, c0 + PERIOD);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (cyc >= c0 + PERIOD) break;
    end
    start = 1'b0;
    repeat (PERIOD + 2) @(negedge clk);

    // Reset after two writes of a burst: outputs clear at once and the rest is abandoned.
    @(negedge clk);
    start = 1'b1;
    score = SCORE_W'(4321);
    @(posedge clk);
    #1;
    c0    = cyc;
    start = 1'b0;
    pushExpected(4321, c0);
    repeat (SCORE_W + 3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    for (int n = 0; n < 3; n++) begin
      checkOutput($sformatf("midrst_wr_en_%0d", n), int'(wrEn[n]), 0);
      checkOutput($sformatf("midrst_addr_%0d", n), int'(wrAddr[n]), 0);
      checkOutput($sformatf("midrst_letter_%0d", n), int'(wrLetter[n]), 0);
      checkOutput($sformatf("midrst_busy_%0d", n), int'(busyO[n]), 0);
      checkOutput($sformatf("midrst_pending_%0d", n), expQ[n].size(), 2);
      expQ[n].delete();
      doneQ[n].delete();
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    applyStimulus(5, 1'b0);

    for (int t = 0; t < 20; t++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      applyStimulus(int'($urandom_range(0, 16383)), 1'b0);
    end

    repeat (4) @(negedge clk);
    for (int n = 0; n < 3; n++) begin
      checkOutput($sformatf("writes_left_inst%0d", n), expQ[n].size(), 0);
      checkOutput($sformatf("dones_left_inst%0d", n), doneQ[n].size(), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
